// File: rtl/hazard_pkg.sv
// Shared types, defaults and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    StRun,
    StLdStall
  } hcu_state_e;

  localparam int unsigned DefRegAw       = 5;
  localparam int unsigned DefLoadStall   = 1;
  localparam int unsigned DefMdLat       = 4;
  localparam int unsigned DefFlushCycles = 1;
  localparam bit          DefZeroExempt  = 1'b1;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_control_unit_md_scoreboard.sv
// Single-entry mul/div scoreboard plus the register-hit comparators for
// load-use and scoreboard hazards.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = DefRegAw,
  parameter int unsigned MD_LAT      = DefMdLat,
  parameter bit          ZERO_EXEMPT = DefZeroExempt
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_md_i,
  input  logic              md_issue_i,
  input  logic [REG_AW-1:0] md_rd_i,
  output logic              ld_use_o,
  output logic              md_hazard_o,
  output logic              md_busy_o
);

  localparam int unsigned    MdW    = cnt_width(MD_LAT);
  localparam logic [MdW-1:0] MdInit = MdW'(MD_LAT - 1);
  localparam logic [MdW-1:0] MdOne  = MdW'(1);

  logic              busy_q, busy_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [MdW-1:0]    cnt_q, cnt_d;

  logic ld_hit_rs, ld_hit_rt, md_hit_rs, md_hit_rt;

  // Register 0 is hardwired, so it only hits when zero exemption is off.
  always_comb begin
    ld_hit_rs = (ex_rt_i == id_rs_i) && (!ZERO_EXEMPT || (id_rs_i != '0));
    ld_hit_rt = (ex_rt_i == id_rt_i) && (!ZERO_EXEMPT || (id_rt_i != '0));
    md_hit_rs = (dst_q == id_rs_i) && (!ZERO_EXEMPT || (id_rs_i != '0));
    md_hit_rt = (dst_q == id_rt_i) && (!ZERO_EXEMPT || (id_rt_i != '0));
  end

  assign ld_use_o    = ex_memread_i & (ld_hit_rs | ld_hit_rt);
  assign md_hazard_o = busy_q & (md_hit_rs | md_hit_rt | id_md_i);
  assign md_busy_o   = busy_q;

  // A new issue takes priority over the retiring entry.
  always_comb begin
    busy_d = busy_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    if (md_issue_i) begin
      busy_d = 1'b1;
      dst_d  = md_rd_i;
      cnt_d  = MdInit;
    end else if (busy_q) begin
      if (cnt_q == MdOne) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - MdOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      dst_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller beside ID: load-use stall FSM, mul/div scoreboard and
// multi-cycle branch/jump flush window.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = DefRegAw,
  parameter int unsigned LOAD_STALL   = DefLoadStall,
  parameter int unsigned MD_LAT       = DefMdLat,
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles,
  parameter bit          ZERO_EXEMPT  = DefZeroExempt
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_md_i,
  input  logic              md_issue_i,
  input  logic [REG_AW-1:0] md_rd_i,
  input  logic              jump_i,
  input  logic              branch_taken_i,
  output logic              bubble_o,
  output logic              hold_pc_o,
  output logic              hold_ifid_o,
  output logic              flush_o,
  output logic              ifid_rst_n_o,
  output logic              md_busy_o
);

  localparam int unsigned    LdW    = cnt_width(LOAD_STALL);
  localparam int unsigned    FlW    = cnt_width(FLUSH_CYCLES);
  localparam logic [LdW-1:0] LdInit = LdW'(LOAD_STALL - 1);
  localparam logic [LdW-1:0] LdOne  = LdW'(1);
  localparam logic [FlW-1:0] FlInit = FlW'(FLUSH_CYCLES - 1);
  localparam logic [FlW-1:0] FlOne  = FlW'(1);

  hcu_state_e     state_q, state_d;
  logic [LdW-1:0] ld_cnt_q, ld_cnt_d;
  logic [FlW-1:0] fl_cnt_q, fl_cnt_d;

  logic ld_use, md_hazard, md_busy, stall, flush;

  md_scoreboard #(
    .REG_AW      (REG_AW),
    .MD_LAT      (MD_LAT),
    .ZERO_EXEMPT (ZERO_EXEMPT)
  ) u_md_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_md_i      (id_md_i),
    .md_issue_i   (md_issue_i),
    .md_rd_i      (md_rd_i),
    .ld_use_o     (ld_use),
    .md_hazard_o  (md_hazard),
    .md_busy_o    (md_busy)
  );

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    fl_cnt_d = fl_cnt_q;
    flush    = 1'b0;
    stall    = ld_use | md_hazard | (state_q == StLdStall);

    case (state_q)
      StRun: begin
        if (ld_use && (LOAD_STALL > 1)) begin
          state_d  = StLdStall;
          ld_cnt_d = LdInit;
        end
      end
      StLdStall: begin
        if (ld_cnt_q == LdOne) begin
          state_d  = StRun;
          ld_cnt_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q - LdOne;
        end
      end
      default: begin
        state_d  = StRun;
        ld_cnt_d = '0;
      end
    endcase

    // An open flush window swallows any new branch; a stalled branch is
    // re-evaluated once the stall clears.
    if (fl_cnt_q != '0) begin
      flush    = 1'b1;
      fl_cnt_d = fl_cnt_q - FlOne;
    end else if ((state_q == StRun) && (jump_i || branch_taken_i) && !stall) begin
      flush    = 1'b1;
      fl_cnt_d = FlInit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StRun;
      ld_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign bubble_o     = stall & ~rst_i;
  assign hold_pc_o    = stall & ~rst_i;
  assign hold_ifid_o  = stall & ~rst_i;
  assign flush_o      = flush & ~rst_i;
  assign ifid_rst_n_o = ~(flush & ~rst_i);
  assign md_busy_o    = md_busy & ~rst_i;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge monitor
// pops and compares one entry per cycle.
module tb_hazard_control_unit;

  logic       clk, rst;
  logic       mr, id_md, iss, jmp, br;
  logic [4:0] ex_rt, rs, rt, md_rd;

  logic bubble, hold_pc, hold_ifid, flush, ifid_rst_n, md_busy;
  logic d2_bubble, d2_hold_pc, d2_hold_ifid, d2_flush, d2_ifid_rst_n, d2_busy;

  logic [11:0] exp_q[$];
  string       name_q[$];
  logic [11:0] exp_v, act_v;
  string       nm_v;
  int          checks = 0;
  int          failures = 0;

  // Main DUT: 2-cycle load stall, 4-cycle mul/div, 2-cycle flush, r0 exempt.
  hazard_control_unit #(
    .REG_AW       (5),
    .LOAD_STALL   (2),
    .MD_LAT       (4),
    .FLUSH_CYCLES (2),
    .ZERO_EXEMPT  (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ex_memread_i   (mr),
    .ex_rt_i        (ex_rt),
    .id_rs_i        (rs),
    .id_rt_i        (rt),
    .id_md_i        (id_md),
    .md_issue_i     (iss),
    .md_rd_i        (md_rd),
    .jump_i         (jmp),
    .branch_taken_i (br),
    .bubble_o       (bubble),
    .hold_pc_o      (hold_pc),
    .hold_ifid_o    (hold_ifid),
    .flush_o        (flush),
    .ifid_rst_n_o   (ifid_rst_n),
    .md_busy_o      (md_busy)
  );

  // Second DUT: 1-cycle load stall, r0 not exempt, mul/div and branches idle.
  hazard_control_unit #(
    .REG_AW       (5),
    .LOAD_STALL   (1),
    .MD_LAT       (4),
    .FLUSH_CYCLES (1),
    .ZERO_EXEMPT  (1'b0)
  ) dut2 (
    .clk_i          (clk),
    .rst_i          (rst),
    .ex_memread_i   (mr),
    .ex_rt_i        (ex_rt),
    .id_rs_i        (rs),
    .id_rt_i        (rt),
    .id_md_i        (1'b0),
    .md_issue_i     (1'b0),
    .md_rd_i        (5'd0),
    .jump_i         (1'b0),
    .branch_taken_i (1'b0),
    .bubble_o       (d2_bubble),
    .hold_pc_o      (d2_hold_pc),
    .hold_ifid_o    (d2_hold_ifid),
    .flush_o        (d2_flush),
    .ifid_rst_n_o   (d2_ifid_rst_n),
    .md_busy_o      (d2_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // r: reset; s/f/bsy: expected stall, flush, md_busy on dut; b2: stall on dut2.
  task automatic step(input logic r, input logic m, input logic [4:0] e, input logic [4:0] a,
                      input logic [4:0] b, input logic idm, input logic is, input logic [4:0] d,
                      input logic j, input logic bt, input logic s, input logic f,
                      input logic bsy, input logic b2, input string nm);
    @(posedge clk);
    #1;
    rst = r; mr = m; ex_rt = e; rs = a; rt = b;
    id_md = idm; iss = is; md_rd = d; jmp = j; br = bt;
    exp_q.push_back({s, s, s, f, ~f, bsy, b2, b2, b2, 1'b0, 1'b1, 1'b0});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      nm_v  = name_q.pop_front();
      act_v = {bubble, hold_pc, hold_ifid, flush, ifid_rst_n, md_busy,
               d2_bubble, d2_hold_pc, d2_hold_ifid, d2_flush, d2_ifid_rst_n, d2_busy};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", nm_v, act_v, exp_v);
      end
    end
  end

  initial begin
    rst = 1'b1; mr = 1'b0; ex_rt = '0; rs = '0; rt = '0;
    id_md = 1'b0; iss = 1'b0; md_rd = '0; jmp = 1'b0; br = 1'b0;

    //   r  m  ert rs rt idm is rd  j  br   s  f  bsy b2
    step(1, 1, 3, 3, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, "reset_forced");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "reset_idle");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "idle");
    step(0, 1, 3, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, "lu_detect");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, "lu_stall2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "lu_release");
    step(0, 1, 0, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, "zero_reg");
    step(0, 1, 4, 5, 6, 0, 0, 0, 0, 0,   0, 0, 0, 0, "lu_miss");
    step(0, 0, 4, 4, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "no_load");
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0,   0, 0, 0, 0, "md_issue");
    step(0, 0, 0, 7, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "md_raw_t1");
    step(0, 0, 0, 7, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "md_raw_t2");
    step(0, 0, 0, 7, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "md_raw_t3");
    step(0, 0, 0, 7, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "md_raw_t4");
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,   0, 0, 0, 0, "md_issue2");
    step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0,   1, 0, 1, 0, "struct_t1");
    step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0,   1, 0, 1, 0, "struct_t2");
    step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0,   1, 0, 1, 0, "struct_t3");
    step(0, 0, 0, 1, 2, 1, 0, 0, 0, 0,   0, 0, 0, 0, "struct_free");
    step(0, 0, 0, 0, 0, 0, 1, 10, 0, 0,  0, 0, 0, 0, "md_issue3");
    step(0, 0, 0, 11, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, "md_busy_miss");
    step(0, 0, 0, 0, 10, 0, 0, 0, 0, 0,  1, 0, 1, 0, "md_hit_rt");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, "md_busy_last");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "md_cleared");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, "br_flush1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, "br_flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "br_ignored");
    step(0, 1, 3, 3, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, "br_masked1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, "br_masked2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, "br_after1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, "br_after2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "br_done");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, "jmp_flush1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, "jmp_flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "jmp_done");
    step(1, 1, 5, 0, 5, 0, 1, 6, 0, 1,   0, 0, 0, 0, "rst_with_events");
    step(0, 0, 0, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "rst_events_gone");
    step(0, 1, 5, 0, 5, 0, 0, 0, 0, 0,   1, 0, 0, 1, "lu_before_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "rst_mid_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "post_rst_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, "fl_before_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "rst_mid_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "post_rst_flush");
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0,   0, 0, 0, 0, "md_before_rst");
    step(0, 0, 0, 6, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "md_busy_pre");
    step(1, 0, 0, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "rst_mid_md");
    step(0, 0, 0, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "post_rst_md");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
